round_pack_unit: RTL and testbench
==================================

Name: round_pack_unit

Overview:
- Stage directly downstream of the normalizer. Takes the normalized 24-bit mantissa, 8-bit exponent, sign and guard/round/sticky bits.
- Applies round-to-nearest-even and renormalizes on a rounding carry-out.
- Handles zero, underflow and overflow, then packs the IEEE-754 single-precision result.
- Multi-cycle FSM with a start-edge handshake, a one-cycle valid pulse and a busy flag.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, exponent width.
- EXP_MAX, 8'hFF, all-ones exponent (Inf encoding).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset. Active-low, asynchronous.
- enable  input  1  start request; its rising edge launches one operation.
- sign  input  1  result sign.
- mantissa  input  24  normalized mantissa; bit 23 is the hidden bit.
- exponent  input  8  biased exponent from the normalizer.
- guard  input  1  first bit below the mantissa LSB.
- round  input  1  second bit below the mantissa LSB.
- sticky  input  1  OR of all lower bits.
- result  output  32  packed {sign, exp, frac[22:0]}.
- valid  output  1  one-cycle pulse when result updates.
- busy  output  1  high while an operation is in flight.
- overflow  output  1  sticky-until-next-op overflow flag.
- underflow  output  1  sticky-until-next-op underflow/flush flag.

Behaviour:
- Reset (Reset=0, async): state=IDLE; enable_d, result, valid, busy, overflow and underflow all 0.
- Start detection: start = enable & ~enable_d, with enable_d registered every cycle.
  - Start is honoured only in IDLE.
  - A start edge while busy is dropped; it is not queued.
- States: IDLE -> ROUND -> ADJUST -> PACK -> DONE -> IDLE.
- E0, IDLE with start:
  - Register sign, mantissa, exponent, guard, round, sticky.
  - Clear overflow and underflow; busy=1; go to ROUND.
- E1, ROUND:
  - inc = guard & (round | sticky | mantissa[0]).
  - Register the 25-bit sum {1'b0, mantissa} + inc; go to ADJUST.
- E2, ADJUST:
  - If sum[24]=1: mant = sum[24:1], exp = exponent+1.
  - Otherwise: mant = sum[23:0], exp = exponent.
  - Compute exp in 9 bits so exponent 0xFF+1 is detected rather than wrapped.
  - Go to PACK.
- E3, PACK, in priority order:
  - mant==0 -> result = {sign, 31'b0}; no flag.
  - exp==0 with mant!=0 -> result = {sign, 31'b0}; underflow=1 (flush, no denormals).
  - exp >= EXP_MAX -> overflow=1; result = {sign, 8'hFF, 23'b0}.
  - Otherwise -> result = {sign, exp[7:0], mant[22:0]}.
  - valid=1; go to DONE.
- E4, DONE: valid=0, busy=0, go to IDLE.
- Timing:
  - Fixed latency: valid is high in the cycle after edge E3.
  - busy is high from E0 to E4.
  - Minimum start-to-start spacing is 5 cycles plus an enable low phase.
- Holding: result, overflow and underflow hold their values until the next E0/E3. Inputs may change freely after E0.
- Reset mid-operation: the FSM aborts to IDLE immediately and all outputs are cleared. No valid is produced for the aborted operation.
- enable held high across reset release: the edge detector starts from enable_d=0. If enable=1 at the first active edge, that counts as a start.

Optional Feature:
- Macro OVF_SATURATE_EN.
- Defined: on overflow, result = {sign, 8'hFE, 23'h7FFFFF} (max finite); overflow flag is still set.
- Undefined: on overflow, result is signed infinity as in Behaviour.

Test Plan:
- Exact value: mantissa=0xC00000, exponent=0x7F, sign=0, g/r/s=000, enable rising -> valid 4 edges later; result=0x3FC00000, flags 0.
- Ties to even, odd LSB: mantissa=0x800001, exponent=0x7F, g/r/s=100 -> result=0x3F800001+1=0x3F800002.
- Ties to even, even LSB: mantissa=0x800000, g/r/s=100 -> result=0x3F800000.
- Carry renormalize: mantissa=0xFFFFFF, exponent=0x7F, g=1 -> result=0x40000000.
- Overflow: mantissa=0xFFFFFF, exponent=0xFE, g=1 -> result=0x7F800000, overflow=1. With OVF_SATURATE_EN: result=0x7F7FFFFF.
- Zero, underflow and reset:
  - mantissa=0, sign=1 -> result=0x80000000.
  - mantissa=0x800000, exponent=0 -> result=0x00000000, underflow=1.
  - Reset=0 asserted in ADJUST -> busy=0, valid never pulses, result=0.

Source files
------------

// File: rtl/round_pack_unit.sv
// Round-to-nearest-even and IEEE-754 single-precision pack stage behind the normalizer.
// Define OVF_SATURATE_EN to saturate overflow to max finite instead of signed infinity.
module round_pack_unit #(
  parameter int                 MANT_W  = 24,
  parameter int                 EXP_W   = 8,
  parameter logic [EXP_W-1:0]   EXP_MAX = 8'hFF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      enable,
  input  logic                      sign,
  input  logic [MANT_W-1:0]         mantissa,
  input  logic [EXP_W-1:0]          exponent,
  input  logic                      guard,
  input  logic                      round,
  input  logic                      sticky,
  output logic [EXP_W+MANT_W-1:0]   result,
  output logic                      valid,
  output logic                      busy,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int RES_W = EXP_W + MANT_W;

  typedef enum logic [2:0] {IDLE, ROUND, ADJUST, PACK, DONE} state_t;

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [RES_W-1:0] ovf_value(input logic sgn);
`ifdef OVF_SATURATE_EN
    return {sgn, EXP_MAX - EXP_W'(1), {(MANT_W-1){1'b1}}};
`else
    return {sgn, EXP_MAX, {(MANT_W-1){1'b0}}};
`endif
  endfunction

  state_t             state_q, state_d;
  logic               enable_prev_q;
  logic [RES_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               sign_q, sign_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               g_q, g_d, r_q, r_d, s_q, s_d;
  logic [MANT_W:0]    sum_q, sum_d;
  logic [MANT_W-1:0]  norm_q, norm_d;
  logic [EXP_W:0]     exp9_q, exp9_d;
  logic               start;

  always_comb begin
    start    = enable & ~enable_prev_q;
    state_d  = state_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    sign_d   = sign_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    sum_d    = sum_q;
    norm_d   = norm_q;
    exp9_d   = exp9_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = sign;
          mant_d  = mantissa;
          exp_d   = exponent;
          g_d     = guard;
          r_d     = round;
          s_d     = sticky;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        sum_d   = {1'b0, mant_q} + (MANT_W+1)'(rne_inc(mant_q[0], g_q, r_q, s_q));
        state_d = ADJUST;
      end
      ADJUST: begin
        // 9-bit exponent so a carry out of 0xFF is seen as overflow, not wrap
        if (sum_q[MANT_W]) begin
          norm_d = sum_q[MANT_W:1];
          exp9_d = {1'b0, exp_q} + (EXP_W+1)'(1);
        end else begin
          norm_d = sum_q[MANT_W-1:0];
          exp9_d = {1'b0, exp_q};
        end
        state_d = PACK;
      end
      PACK: begin
        if (norm_q == '0) begin
          result_d = {sign_q, {(RES_W-1){1'b0}}};
        end else if (exp9_q == '0) begin
          result_d = {sign_q, {(RES_W-1){1'b0}}};
          unf_d    = 1'b1;
        end else if (exp9_q >= {1'b0, EXP_MAX}) begin
          result_d = ovf_value(sign_q);
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp9_q[EXP_W-1:0], norm_q[MANT_W-2:0]};
        end
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      enable_prev_q <= 1'b0;
      result_q      <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_prev_q <= enable;
      result_q      <= result_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
    end
  end

  // Datapath holding registers carry no reset; they are always written before use
  always_ff @(posedge Clk) begin
    sign_q <= sign_d;
    mant_q <= mant_d;
    exp_q  <= exp_d;
    g_q    <= g_d;
    r_q    <= r_d;
    s_q    <= s_d;
    sum_q  <= sum_d;
    norm_q <= norm_d;
    exp9_q <= exp9_d;
  end

  assign result    = result_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_round_pack_unit.sv
// Self-checking bench for round_pack_unit: directed vectors, random ops against a value-level model.
module tb_round_pack_unit;

  logic        Clk;
  logic        Reset;
  logic        enable;
  logic        sign;
  logic [23:0] mantissa;
  logic [7:0]  exponent;
  logic        guard, round, sticky;
  logic [31:0] result;
  logic        valid, busy, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  round_pack_unit dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .sign(sign), .mantissa(mantissa),
    .exponent(exponent), .guard(guard), .round(round), .sticky(sticky),
    .result(result), .valid(valid), .busy(busy), .overflow(overflow), .underflow(underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Value-level reference: returns {overflow, underflow, result}
  function automatic logic [33:0] model(input logic s, input logic [23:0] m, input logic [7:0] e,
                                        input logic g, input logic r, input logic st);
    longint mm = longint'(m);
    int     ee = int'(e);
    logic [31:0] res;
    logic ov = 1'b0, un = 1'b0;
    logic [7:0]  e8;
    logic [23:0] m24;
    if (g && (r || st)) mm = mm + 1;             // above half
    else if (g && (mm % 2 == 1)) mm = mm + 1;    // exact tie, go to even
    if (mm == (64'd1 << 24)) begin mm = mm / 2; ee = ee + 1; end
    m24 = 24'(mm);
    e8  = 8'(ee);
    if (mm == 0) res = {s, 31'h0};
    else if (ee == 0) begin res = {s, 31'h0}; un = 1'b1; end
    else if (ee >= 255) begin
      ov = 1'b1;
`ifdef OVF_SATURATE_EN
      res = {s, 8'hFE, 23'h7FFFFF};
`else
      res = {s, 8'hFF, 23'h0};
`endif
    end else res = {s, e8, m24[22:0]};
    return {ov, un, res};
  endfunction

  // Drives one operation, returns what was seen at the valid pulse and the cycle after it.
  task automatic do_op(input logic s, input logic [23:0] m, input logic [7:0] e,
                       input logic g, input logic r, input logic st,
                       output logic [31:0] res, output logic ov, output logic un,
                       output int lat, output logic v_after, output logic b_after);
    @(negedge Clk);
    sign = s; mantissa = m; exponent = e; guard = g; round = r; sticky = st;
    enable = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk); #1;
      if (valid) begin lat = i; break; end
    end
    res = result; ov = overflow; un = underflow;
    @(posedge Clk); #1;
    v_after = valid; b_after = busy;
    @(negedge Clk); enable = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b0; enable = 1'b0; sign = 0; mantissa = 0; exponent = 0;
    guard = 0; round = 0; sticky = 0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({result, valid, busy, overflow, underflow} !== 36'h0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0", {result, valid, busy, overflow, underflow});
    end
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_directed;
    logic [31:0] res; logic ov, un, va, ba; int lat;
    logic [23:0] tm [8] = '{24'hC00000, 24'h800001, 24'h800000, 24'hFFFFFF, 24'hFFFFFF,
                            24'h000000, 24'h800000, 24'h800001};
    logic [7:0]  te [8] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFE, 8'h55, 8'h00, 8'h7F};
    logic [3:0]  tsgrs [8] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0000, 4'b0010};
`ifdef OVF_SATURATE_EN
    logic [31:0] tres [8] = '{32'h3FC00000, 32'h3F800002, 32'h3F800000, 32'h40000000, 32'h7F7FFFFF,
                              32'h80000000, 32'h00000000, 32'h3F800001};
`else
    logic [31:0] tres [8] = '{32'h3FC00000, 32'h3F800002, 32'h3F800000, 32'h40000000, 32'h7F800000,
                              32'h80000000, 32'h00000000, 32'h3F800001};
`endif
    logic [1:0]  tflg [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 8; i++) begin
      do_op(tsgrs[i][3], tm[i], te[i], tsgrs[i][2], tsgrs[i][1], tsgrs[i][0], res, ov, un, lat, va, ba);
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d required=4", i, lat);
      end
      checks++;
      if (res !== tres[i]) begin
        failures++;
        $display("FAIL dir%0d_result got=%h required=%h", i, res, tres[i]);
      end
      checks++;
      if ({ov, un} !== tflg[i]) begin
        failures++;
        $display("FAIL dir%0d_flags got=%b required=%b", i, {ov, un}, tflg[i]);
      end
      checks++;
      if ({va, ba} !== 2'b00) begin
        failures++;
        $display("FAIL dir%0d_done valid/busy got=%b required=00", i, {va, ba});
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] res; logic ov, un, va, ba; int lat;
    logic [33:0] exp_v;
    logic [31:0] rnd;
    logic [23:0] m; logic [7:0] e; logic s, g, r, st;
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom;
      m = {1'b1, rnd[22:0]};
      if (rnd[31:29] == 3'd0) m = 24'hFFFFFF;
      if (rnd[28:25] == 4'd0) m = 24'h0;
      rnd = $urandom;
      case (rnd[10:8])
        3'd0: e = 8'h00;
        3'd1: e = 8'hFE;
        3'd2: e = 8'hFF;
        default: e = rnd[7:0];
      endcase
      s = rnd[12]; g = rnd[13]; r = rnd[14]; st = rnd[15];
      exp_v = model(s, m, e, g, r, st);
      do_op(s, m, e, g, r, st, res, ov, un, lat, va, ba);
      checks++;
      if (lat != 4 || {ov, un, res} !== exp_v) begin
        failures++;
        $display("FAIL rand%0d got lat=%0d ovf/unf/res=%b/%b/%h required lat=4 %b/%b/%h (m=%h e=%h grs=%b%b%b)",
                 i, lat, ov, un, res, exp_v[33], exp_v[32], exp_v[31:0], m, e, g, r, st);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [33:0] exp_v;
    int lat; int extra;
    exp_v = model(1'b0, 24'hA00000, 8'h80, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    sign = 0; mantissa = 24'hA00000; exponent = 8'h80; guard = 0; round = 0; sticky = 0;
    enable = 1'b1;
    @(negedge Clk);
    mantissa = 24'hFFFFFF; exponent = 8'h01; enable = 1'b0;
    @(negedge Clk);
    enable = 1'b1;  // new edge while busy: must be dropped
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++;
    if (lat == 0 || result !== exp_v[31:0]) begin
      failures++;
      $display("FAIL busy_first_op got lat=%0d res=%h required res=%h", lat, result, exp_v[31:0]);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (valid) extra++;
    end
    checks++;
    if (extra != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop got extra_valid=%0d busy=%b required 0/0", extra, busy);
    end
    @(negedge Clk); enable = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_op;
    int vcount;
    @(negedge Clk);
    sign = 0; mantissa = 24'hC00000; exponent = 8'h90; guard = 0; round = 0; sticky = 0;
    enable = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;  // now in ADJUST
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midop_busy got=%b required=1", busy);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({busy, valid, result, overflow, underflow} !== 36'h0) begin
      failures++;
      $display("FAIL midop_reset_clear got busy=%b valid=%b res=%h required 0/0/0", busy, valid, result);
    end
    @(negedge Clk); enable = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (valid) vcount++;
    end
    checks++;
    if (vcount != 0 || result !== 32'h0) begin
      failures++;
      $display("FAIL midop_no_valid got valids=%0d res=%h required 0/0", vcount, result);
    end
  endtask

  task automatic test_enable_across_reset;
    int lat;
    @(negedge Clk);
    Reset = 1'b0;
    sign = 1; mantissa = 24'h900000; exponent = 8'h81; guard = 0; round = 0; sticky = 0;
    enable = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++;
    if (lat != 4 || result !== 32'hC0900000) begin
      failures++;
      $display("FAIL en_across_reset got lat=%0d res=%h required lat=4 res=c0900000", lat, result);
    end
    @(negedge Clk); enable = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid_op;
    test_enable_across_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
